matrix_stream_loader: RTL and testbench

Replaces the debug-probe matrix source in front of vga_rtl_top. It accepts a valid/ready element stream, packs two MATRIX_N x MATRIX_M operand matrices into shadow registers, and commits them to the flat matrix_a/matrix_b buses. It then drives the read_ready / compute_done handshake with the compute/display core. Because the shadow buffer is separate from the output buses, the next operand pair loads while the core is still working on the current one.

---
 rtl/matrix_stream_loader_pkg.sv | 12 +
 rtl/matrix_stream_loader_if.sv | 9 +
 rtl/matrix_stream_loader_shadow_regs.sv | 24 ++
 rtl/matrix_stream_loader.sv | 60 ++++++
 tb/tb_matrix_stream_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/matrix_stream_loader_pkg.sv
// matrix_pkg: frame geometry helpers shared by the matrix stream loader.
package matrix_pkg;
  function automatic int frame_len(input int n, input int m);
    return 2 * n * m;
  endfunction
  function automatic int idx_width(input int n, input int m);
    return $clog2(2 * n * m);
  endfunction
  function automatic int elem_lsb(input int r, input int c, input int m, input int width);
    return (r * m + c) * width;
  endfunction
endpackage

// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_if: valid/ready element stream feeding the matrix loader.
interface matrix_stream_if #(parameter int WIDTH = 16);
  logic s_valid;
  logic [WIDTH-1:0] s_data;
  logic s_last;
  logic s_ready;
  modport master(output s_valid, s_data, s_last, input s_ready);
  modport slave(input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/matrix_stream_loader_shadow_regs.sv
// matrix_shadow_regs: shadow register file holding A (low half) then B, row-major.
module matrix_shadow_regs import matrix_pkg::*; #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int WIDTH = 16,
  localparam int IW = idx_width(MATRIX_N, MATRIX_M),
  localparam int NM = MATRIX_N * MATRIX_M
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [IW-1:0] idx,
  input  logic [WIDTH-1:0] data,
  output logic [2*NM*WIDTH-1:0] shadow
);
  always_ff @(posedge clk or posedge reset)
    if (reset) shadow <= '0;
    else
      for (int s = 0; s < 2; s++)
        for (int r = 0; r < MATRIX_N; r++)
          for (int c = 0; c < MATRIX_M; c++)
            if (we && idx == IW'(s * NM + r * MATRIX_M + c))
              shadow[s * NM * WIDTH + elem_lsb(r, c, MATRIX_M, WIDTH) +: WIDTH] <= data;
endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: packs a streamed A/B operand pair into shadow regs and commits it to the compute core.
module matrix_stream_loader import matrix_pkg::*; #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  matrix_stream_if.slave s,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_a,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_b,
  output logic read_ready,
  input  logic compute_done,
  output logic busy,
  output logic err_len,
  output logic [15:0] launch_count
);
  localparam int NM = MATRIX_N * MATRIX_M;
  localparam int FL = frame_len(MATRIX_N, MATRIX_M);
  localparam int IW = idx_width(MATRIX_N, MATRIX_M);
  localparam logic [IW-1:0] LAST = IW'(FL - 1);
  logic [IW-1:0] idx;
  logic shadow_full;
  logic [2*NM*WIDTH-1:0] shadow;
  logic xfer, at_last, commit;
  assign s.s_ready = !shadow_full && !reset;
  assign xfer = s.s_valid && s.s_ready;
  assign at_last = idx == LAST;
  assign commit = shadow_full && !read_ready;
  assign busy = read_ready;
  matrix_shadow_regs #(.MATRIX_N(MATRIX_N), .MATRIX_M(MATRIX_M), .WIDTH(WIDTH)) u_shadow (
    .clk(clk),
    .reset(reset),
    .we(xfer),
    .idx(idx),
    .data(s.s_data),
    .shadow(shadow)
  );
  // a frame is good only when s_last coincides exactly with the final slot
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      shadow_full <= 1'b0;
      read_ready <= 1'b0;
      matrix_a <= '0;
      matrix_b <= '0;
      err_len <= 1'b0;
      launch_count <= '0;
    end else begin
      if (xfer) idx <= (s.s_last || at_last) ? '0 : idx + 1'b1;
      err_len <= xfer && (s.s_last != at_last);
      shadow_full <= (xfer && at_last && s.s_last) ? 1'b1 : (commit ? 1'b0 : shadow_full);
      read_ready <= commit ? 1'b1 : (compute_done ? 1'b0 : read_ready);
      if (commit) begin
        matrix_a <= shadow[NM*WIDTH-1:0];
        matrix_b <= shadow[2*NM*WIDTH-1 -: NM*WIDTH];
        launch_count <= launch_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: randomized stream stimulus checked against a queue-based frame model.
module tb_matrix_stream_loader;
  localparam int N = 3, M = 3, W = 16, NM = N * M, FL = 2 * NM;
  logic clk = 0, reset = 1, compute_done = 0;
  logic [NM*W-1:0] matrix_a, matrix_b;
  logic read_ready, busy, err_len;
  logic [15:0] launch_count;
  int checks = 0, errors = 0;
  matrix_stream_if #(.WIDTH(W)) s();
  matrix_stream_loader #(.MATRIX_N(N), .MATRIX_M(M), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .s(s), .matrix_a(matrix_a), .matrix_b(matrix_b),
    .read_ready(read_ready), .compute_done(compute_done), .busy(busy),
    .err_len(err_len), .launch_count(launch_count));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NM*W-1:0] act, input logic [NM*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: a frame is a queue of received elements; a complete pair waits as pend
  logic [W-1:0] q[$];
  logic [W-1:0] pend[FL];
  logic [W-1:0] ma[NM], mb[NM];
  bit m_full, m_rr, m_err;
  int m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_full = 0; m_rr = 0; m_err = 0; m_cnt = 0;
      for (int k = 0; k < NM; k++) begin ma[k] = '0; mb[k] = '0; end
    end else begin
      bit xfer, commit;
      xfer = s.s_valid && !m_full;
      commit = m_full && !m_rr;
      m_err = 0;
      if (commit) begin
        for (int k = 0; k < NM; k++) begin ma[k] = pend[k]; mb[k] = pend[NM + k]; end
        m_full = 0; m_rr = 1; m_cnt = (m_cnt + 1) % 65536;
      end else if (m_rr && compute_done) m_rr = 0;
      if (xfer) begin
        q.push_back(s.s_data);
        if (q.size() == FL && s.s_last) begin
          for (int k = 0; k < FL; k++) pend[k] = q[k];
          m_full = 1;
          q.delete();
        end else if (s.s_last || q.size() == FL) begin
          m_err = 1;
          q.delete();
        end
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    logic [NM*W-1:0] ea, eb;
    for (int k = 0; k < NM; k++) begin ea[k*W +: W] = ma[k]; eb[k*W +: W] = mb[k]; end
    chk("s_ready", s.s_ready, m_full ? 0 : 1);
    chk("read_ready", read_ready, m_rr);
    chk("busy", busy, m_rr);
    chk("err_len", err_len, m_err);
    chk("launch_count", launch_count, m_cnt);
    chk("matrix_a", matrix_a, ea);
    chk("matrix_b", matrix_b, eb);
  end

  function automatic logic [NM*W-1:0] build(input int base);
    logic [NM*W-1:0] v;
    for (int k = 0; k < NM; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input int gap);
    int t = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      s.s_valid = 0; s.s_data = W'($urandom);
      cyc(1);
    end
    s.s_valid = 1; s.s_data = d; s.s_last = l;
    forever begin
      logic acc;
      acc = s.s_ready;
      cyc(1);
      if (acc) break;
      if (++t > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: element %0d not accepted", d);
        break;
      end
    end
    s.s_valid = 0; s.s_last = 0; s.s_data = W'($urandom);
  endtask

  task automatic frame(input int base, input int gap, input int last_at);
    for (int i = 1; i <= FL; i++) begin
      send(W'(base + i - 1), i == last_at, gap);
      if (i == last_at) break;
    end
  endtask

  task automatic done_pulse();
    compute_done = 1;
    cyc(1);
    compute_done = 0;
  endtask

  task automatic wait_rr();
    int t = 0;
    while (!read_ready && t < 100) begin cyc(1); t++; end
    chk("wait_read_ready", read_ready, 1);
  endtask

  initial begin
    s.s_valid = 0; s.s_data = '0; s.s_last = 0;
    cyc(3);
    chk("rst_s_ready", s.s_ready, 0);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_matrix_a", matrix_a, 0);
    chk("rst_launch", launch_count, 0);
    reset = 0;
    cyc(2);
    frame(1, 0, 18);
    chk("t1_rr_at_accept", read_ready, 0);
    cyc(1);
    chk("t1_rr", read_ready, 1);
    chk("t1_a_first", matrix_a[15:0], 1);
    chk("t1_a_last", matrix_a[143:128], 9);
    chk("t1_b_first", matrix_b[15:0], 10);
    chk("t1_b_last", matrix_b[143:128], 18);
    chk("t1_launch", launch_count, 1);
    done_pulse();
    chk("t1_rr_clear", read_ready, 0);
    frame(50, 0, 7);
    chk("early_err", err_len, 1);
    chk("early_s_ready", s.s_ready, 1);
    chk("early_a_kept", matrix_a[15:0], 1);
    cyc(1);
    chk("early_err_once", err_len, 0);
    frame(20, 0, 18);
    cyc(1);
    chk("after_early_a", matrix_a, build(20));
    chk("after_early_launch", launch_count, 2);
    done_pulse();
    frame(60, 0, 0);
    chk("missing_err", err_len, 1);
    cyc(3);
    chk("missing_launch", launch_count, 2);
    chk("missing_rr", read_ready, 0);
    frame(1, 0, 18);
    cyc(1);
    chk("ovl_launch3", launch_count, 3);
    frame(100, 0, 18);
    cyc(2);
    chk("ovl_s_ready", s.s_ready, 0);
    chk("ovl_a_kept", matrix_a[15:0], 1);
    chk("ovl_rr", read_ready, 1);
    done_pulse();
    chk("ovl_rr_gap", read_ready, 0);
    cyc(1);
    chk("ovl_rr_again", read_ready, 1);
    chk("ovl_a_new", matrix_a[15:0], 100);
    chk("ovl_launch4", launch_count, 4);
    done_pulse();
    for (int f = 0; f < 3; f++) begin
      frame(1, 30, 18);
      wait_rr();
      chk("gap_a", matrix_a, build(1));
      chk("gap_b", matrix_b, build(10));
      done_pulse();
    end
    frame(1, 0, 18);
    cyc(1);
    chk("pre_rst_rr", read_ready, 1);
    for (int i = 0; i < 8; i++) send(W'(200 + i), 0, 0);
    #2 reset = 1;
    #1;
    chk("mid_rst_rr", read_ready, 0);
    chk("mid_rst_s_ready", s.s_ready, 0);
    chk("mid_rst_a", matrix_a, 0);
    chk("mid_rst_b", matrix_b, 0);
    chk("mid_rst_launch", launch_count, 0);
    cyc(2);
    reset = 0;
    cyc(1);
    frame(1, 0, 18);
    cyc(1);
    chk("post_rst_rr", read_ready, 1);
    chk("post_rst_a", matrix_a, build(1));
    chk("post_rst_b", matrix_b, build(10));
    chk("post_rst_launch", launch_count, 1);
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
